// File: rtl/axis_frame_pkg.sv
// Shared constants, FSM state type and LFSR helper for the AXI-Stream frame checker.
package axis_frame_pkg;

    localparam int TUSER_SOF = 0;
    localparam int TUSER_EOF = 1;
    localparam int TUSER_SOL = 2;
    localparam int TUSER_EOL = 3;

    localparam int ERR_SOF_IN_FRAME  = 0;
    localparam int ERR_OUTSIDE_FRAME = 1;
    localparam int ERR_SOL_IN_LINE   = 2;
    localparam int ERR_EOL_TLAST     = 3;
    localparam int ERR_BEATS         = 4;
    localparam int ERR_LINES         = 5;
    localparam int ERR_WIDTH         = 6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Bit-reversed form of 0x04C11DB7 for the LSB-first CRC-32 datapath
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_FRAME = 2'd1,
        ST_IN_LINE  = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/axis_frame_crc32.sv
// Running CRC-32 over full data words, little-endian byte order, LSB-first bits.
// Only instantiated when AXIS_FRAME_CRC_EN is defined.
module axis_frame_crc32
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  aclk,
    input  logic                  aclk_reset_n,
    input  logic                  clr,
    input  logic                  beat,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           crc_final
);

    logic [31:0] crc;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = restart ? 32'hFFFF_FFFF : crc;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            crc_nxt = (crc_nxt >> 1) ^ ((crc_nxt[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
        end
    end

    assign crc_final = ~crc_nxt;

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            crc <= 32'hFFFF_FFFF;
        end else if (clr) begin
            crc <= 32'hFFFF_FFFF;
        end else if (beat) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream frame/line structure checker with LFSR backpressure and sticky error flags.
// Optional frame CRC enabled by defining AXIS_FRAME_CRC_EN.
//
// state       | meaning
// ST_IDLE     | outside any frame, waiting for SOF
// ST_IN_FRAME | inside a frame, between lines
// ST_IN_LINE  | inside a line, counting beats
module axis_frame_checker
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aclk_reset_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  cfg_bp_en,
    input  logic [15:0]           cfg_bp_seed,
    input  logic [CNT_WIDTH-1:0]  cfg_exp_beats,
    input  logic [CNT_WIDTH-1:0]  cfg_exp_lines,
    input  logic                  clr,
    output logic                  frame_done,
    output logic [31:0]           frame_count,
    output logic [CNT_WIDTH-1:0]  last_line_beats,
    output logic [CNT_WIDTH-1:0]  last_frame_lines,
    output logic [ERR_WIDTH-1:0]  err_flags,
    output logic [31:0]           frame_crc
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                 state, state_nxt;
    logic [15:0]            lfsr, lfsr_nxt;
    logic [CNT_WIDTH-1:0]   beat_cnt, beat_nxt, line_cnt, line_nxt;
    logic [CNT_WIDTH-1:0]   llb_nxt, lfl_nxt;
    logic [ERR_WIDTH-1:0]   err_nxt;
    logic [31:0]            fc_nxt;
    logic                   done_nxt;
    logic                   accept, drop, start;
    logic                   sof, eof, sol, eol;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign sof    = s_axis_tuser[TUSER_SOF];
    assign eof    = s_axis_tuser[TUSER_EOF];
    assign sol    = s_axis_tuser[TUSER_SOL];
    assign eol    = s_axis_tuser[TUSER_EOL];

    assign lfsr_nxt = !clr ? lfsr_step(lfsr) :
                      (cfg_bp_seed == 16'h0) ? LFSR_SEED : cfg_bp_seed;

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        line_nxt  = line_cnt;
        llb_nxt   = last_line_beats;
        lfl_nxt   = last_frame_lines;
        err_nxt   = err_flags;
        fc_nxt    = frame_count;
        done_nxt  = 1'b0;
        drop      = 1'b1;
        start     = 1'b0;
        if (accept) begin
            if ((s_axis_tlast != eol) || (eof && !eol)) err_nxt[ERR_EOL_TLAST] = 1'b1;
            unique case (state)
                ST_IDLE: begin
                    drop  = !sof;
                    start = sof;
                    if (!sof) err_nxt[ERR_OUTSIDE_FRAME] = 1'b1;
                end
                ST_IN_FRAME: begin
                    drop  = !(sof || sol);
                    start = sof || sol;
                    if (sof)       err_nxt[ERR_SOF_IN_FRAME]  = 1'b1;
                    else if (!sol) err_nxt[ERR_OUTSIDE_FRAME] = 1'b1;
                end
                default: begin
                    drop  = 1'b0;
                    start = sof || sol;
                    if (sof)      err_nxt[ERR_SOF_IN_FRAME] = 1'b1;
                    else if (sol) err_nxt[ERR_SOL_IN_LINE]  = 1'b1;
                end
            endcase
            if (!drop) begin
                beat_nxt  = start ? CNT_ONE : ((beat_cnt == '1) ? beat_cnt : beat_cnt + CNT_ONE);
                line_nxt  = sof ? '0 : line_cnt;
                state_nxt = ST_IN_LINE;
                // EOF without EOL still closes the line
                if (eol || eof) begin
                    llb_nxt  = beat_nxt;
                    line_nxt = (line_nxt == '1) ? line_nxt : line_nxt + CNT_ONE;
                    if ((cfg_exp_beats != '0) && (beat_nxt != cfg_exp_beats)) err_nxt[ERR_BEATS] = 1'b1;
                    if (eof) begin
                        lfl_nxt   = line_nxt;
                        fc_nxt    = frame_count + 32'd1;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                        if ((cfg_exp_lines != '0) && (line_nxt != cfg_exp_lines)) err_nxt[ERR_LINES] = 1'b1;
                    end else begin
                        state_nxt = ST_IN_FRAME;
                    end
                end
            end
        end
        if (clr) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
            line_nxt  = '0;
            llb_nxt   = '0;
            lfl_nxt   = '0;
            err_nxt   = '0;
            fc_nxt    = '0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            lfsr             <= LFSR_SEED;
            s_axis_tready    <= 1'b0;
            beat_cnt         <= '0;
            line_cnt         <= '0;
            last_line_beats  <= '0;
            last_frame_lines <= '0;
            err_flags        <= '0;
            frame_count      <= '0;
            frame_done       <= 1'b0;
        end else begin
            lfsr             <= lfsr_nxt;
            s_axis_tready    <= !cfg_bp_en || lfsr_nxt[0];
            beat_cnt         <= beat_nxt;
            line_cnt         <= line_nxt;
            last_line_beats  <= llb_nxt;
            last_frame_lines <= lfl_nxt;
            err_flags        <= err_nxt;
            frame_count      <= fc_nxt;
            frame_done       <= done_nxt;
        end
    end

`ifdef AXIS_FRAME_CRC_EN
    logic [31:0] crc_final;
    logic [31:0] crc_q;

    axis_frame_crc32 #(.DATA_WIDTH(DATA_WIDTH)) u_crc (
        .aclk         (aclk),
        .aclk_reset_n (aclk_reset_n),
        .clr          (clr),
        .beat         (accept && !drop && !clr),
        .restart      (sof),
        .data         (s_axis_tdata),
        .crc_final    (crc_final)
    );

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            crc_q <= '0;
        end else if (clr) begin
            crc_q <= '0;
        end else if (done_nxt) begin
            crc_q <= crc_final;
        end
    end

    assign frame_crc = crc_q;
`else
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;
    assign frame_crc    = '0;
`endif

endmodule

// File: doc/axis_frame_checker.md
# axis_frame_checker

Downstream consumer of the system's 64-bit AXI-Stream image output (the stage fed by system_top's tx stream). It accepts beats and applies programmable backpressure. It tracks the frame/line structure carried on tuser and tlast, and measures beats per line and lines per frame. Protocol and geometry violations are reported as sticky error flags with per-frame status. Intended for both the validation bench and on-board loopback diagnostics.

## Interface
Parameters:
- DATA_WIDTH, 64, tdata width; a multiple of 32.
- USER_WIDTH, 4, tuser width; fixed encoding: [0]=SOF, [1]=EOF, [2]=SOL, [3]=EOL.
- CNT_WIDTH, 16, width of the beat and line counters.

Ports:
- aclk  in  1  the single clock.
- aclk_reset_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  backpressure to upstream.
- s_axis_tdata  in  DATA_WIDTH  pixel data.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  USER_WIDTH  frame/line markers.
- cfg_bp_en  in  1  enables pseudo-random backpressure.
- cfg_bp_seed  in  16  LFSR seed, loaded on clr.
- cfg_exp_beats  in  CNT_WIDTH  expected beats per line; 0 disables the check.
- cfg_exp_lines  in  CNT_WIDTH  expected lines per frame; 0 disables the check.
- clr  in  1  synchronous pulse: clears counters and flags, reloads the LFSR.
- frame_done  out  1  one-cycle pulse on the EOF beat.
- frame_count  out  32  number of completed frames.
- last_line_beats  out  CNT_WIDTH  beat count of the most recent completed line.
- last_frame_lines  out  CNT_WIDTH  line count of the most recent completed frame.
- err_flags  out  6  sticky errors: [0] SOF inside a frame, [1] data outside a frame, [2] SOL inside a line, [3] EOL/tlast mismatch, [4] beats≠cfg_exp_beats, [5] lines≠cfg_exp_lines.
- frame_crc  out  32  CRC of the last frame; present only with AXIS_FRAME_CRC_EN.

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- FSM states: IDLE, IN_FRAME (between lines), IN_LINE.
- IDLE:
  - An accepted beat with SOF+SOL goes to IN_LINE; beat count = 1, line count = 0.
  - An accepted beat without SOF sets err[1]; the beat is dropped and the state stays IDLE.
- IN_FRAME:
  - An accepted beat with SOL goes to IN_LINE.
  - An accepted beat without SOL sets err[1].
  - An accepted beat with SOF sets err[0]; the frame restarts and counters reset as for IDLE.
- IN_LINE:
  - Each accepted beat increments the beat count.
  - SOL sets err[2]; the beat counts as the start of a new line.
  - SOF sets err[0] and restarts the frame.
- A line closes on an accepted beat with EOL:
  - last_line_beats ← beat count, line count increments.
  - err[3] if tlast≠EOL on any accepted beat.
  - err[4] if cfg_exp_beats≠0 and the count mismatches.
  - Next state is IN_FRAME, or IDLE if EOF is also set.
- EOF is legal only together with EOL; EOF without EOL sets err[3] and is treated as EOL+EOF.
- On EOF:
  - last_frame_lines ← line count, frame_count++, frame_done pulses.
  - err[5] if cfg_exp_lines≠0 and the count mismatches.
- Single-beat frame (SOF+SOL+EOL+EOF on one beat) is legal: 1 beat, 1 line.
- Counters saturate at all-ones and never wrap; frame_count wraps modulo 2^32.
- Backpressure:
  - s_axis_tready = !cfg_bp_en || lfsr[0].
  - The 16-bit Fibonacci LFSR uses taps 16,14,13,11 and advances every cycle.
  - A zero seed is replaced by 0xACE1.
- clr has priority over any same-cycle beat:
  - The FSM returns to IDLE and flags and counters clear.
  - The beat presented in the clr cycle is accepted but ignored.

## Timing
- Reset values: s_axis_tready=0 during reset, then 1 from the first cycle after deassertion (or per LFSR); frame_done=0; all counters, err_flags and frame_crc = 0; LFSR=0xACE1.
- All outputs are registered; statistics and flags update the cycle after the accepting edge.
- tready does not depend combinationally on tvalid.
- Throughput is one beat per cycle with cfg_bp_en=0.
- Reset asserted mid-frame: the FSM returns to IDLE immediately; the remainder of the partial frame upstream triggers err[1] once, unless it resumes at a SOF.

## Configuration
- AXIS_FRAME_CRC_EN defined:
  - A CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, final XOR) is computed over the tdata of every accepted beat in a frame, little-endian byte order.
  - The CRC is 8 bytes per cycle and is registered into frame_crc with frame_done.
- AXIS_FRAME_CRC_EN undefined: no CRC logic; frame_crc is tied to 0.

## Structure
- Shared package axis_frame_pkg:
  - tuser bit index constants (TUSER_SOF=0, TUSER_EOF=1, TUSER_SOL=2, TUSER_EOL=3).
  - err_flags bit index constants.
  - FSM state enum.
  - LFSR default seed.
- One sub-module: axis_frame_crc32, a 64-bit-per-cycle CRC datapath instantiated only under AXIS_FRAME_CRC_EN.

## Test plan
- Nominal: 2 frames of 4 lines × 8 beats, cfg_exp_beats=8, cfg_exp_lines=4, no backpressure -> frame_count=2, last_line_beats=8, last_frame_lines=4, err_flags=0, two frame_done pulses.
- Geometry error: line 3 of a frame has 7 beats -> err[4]=1 after that EOL, err[5]=0, last_line_beats=8 after the next line.
- Protocol errors: SOF mid-line -> err[0]=1, frame restarts; data beat in IDLE -> err[1]=1; tlast on a non-EOL beat -> err[3]=1.
- Backpressure: cfg_bp_en=1, seed 0x1234, 1 frame of 16×16 with tvalid held -> all 256 beats accepted exactly once, err_flags=0, tready toggles.
- Single-beat frame, then clr on the same cycle as a SOF beat -> first: frame_count=1, lines=1, beats=1; after clr: all counters 0, FSM IDLE.
- With AXIS_FRAME_CRC_EN: one frame of 1 line × 1 beat with tdata=0 -> frame_crc=0x6522DF69 (CRC-32 of 8 zero bytes).
